// File: rtl/resize_ctrl.sv
// resize_ctrl: frame-resize sequencer between the source-image ROM and the VGA
// framebuffer RAM. A start pulse walks the ROM image once and writes a scaled
// copy into the RAM (x1 copy, x2/x4 pixel replication, /2 decimation).
// RAM writes commit only while the framebuffer arbiter grants the port.
// Optional feature macro: RESIZE_CTRL_PERF_EN adds the stall_cnt output, which
// counts WRITE cycles spent waiting for ram_gnt.
module resize_ctrl #(
   parameter int SRC_W = 80,
   parameter int SRC_H = 60,
   parameter int RA_W  = 13,
   parameter int WA_W  = 17
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      mode,
   output logic            busy,
   output logic            done,
   output logic [RA_W-1:0] rom_addr,
   input  logic [7:0]      rom_data,
   input  logic            ram_gnt,
   output logic            ram_we,
   output logic [WA_W-1:0] ram_waddr,
   output logic [7:0]      ram_wdata
`ifdef RESIZE_CTRL_PERF_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_WRITE,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      M_X1   = 2'b00,
      M_X2   = 2'b01,
      M_X4   = 2'b10,
      M_DIV2 = 2'b11
   } mode_t;

   localparam logic [RA_W-1:0] SRC_W_R = RA_W'(SRC_W);
   localparam logic [RA_W-1:0] SRC_H_R = RA_W'(SRC_H);

   state_t          state, state_nxt;
   mode_t           mode_q;
   logic [RA_W-1:0] row, col, row_nxt, col_nxt;
   logic [1:0]      di, dj, di_nxt, dj_nxt;
   logic [7:0]      pix;

   // Per-mode scale decode
   logic [1:0]      f_m1;     // replication factor minus one (dj/di wrap value)
   logic [WA_W-1:0] f_w;      // replication factor F
   logic [WA_W-1:0] dw_w;     // destination row width DW
   logic [RA_W-1:0] stride;   // source step: 2 for decimation, else 1
   logic            col_end, row_end, last_pix;

   // Decode F, DW and the source stride from the latched mode
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      f_m1   = 2'd0;
      f_w    = WA_W'(1);
      dw_w   = WA_W'(SRC_W);
      stride = RA_W'(1);
      case (mode_q)
         M_X2: begin
            f_m1 = 2'd1;
            f_w  = WA_W'(2);
            dw_w = WA_W'(2 * SRC_W);
         end
         M_X4: begin
            f_m1 = 2'd3;
            f_w  = WA_W'(4);
            dw_w = WA_W'(4 * SRC_W);
         end
         M_DIV2: begin
            stride = RA_W'(2);
            dw_w   = WA_W'(SRC_W / 2);
         end
         default: ;
      endcase
   end

   // Edge detection on the source walk; compared against size-stride so a
   // full-width counter can never overflow while stepping
   always_comb begin
      col_end  = (col >= (SRC_W_R - stride));
      row_end  = (row >= (SRC_H_R - stride));
      last_pix = col_end && row_end;
   end

   // Next-state and counter-advance logic
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      di_nxt    = di;
      dj_nxt    = dj;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
               row_nxt   = '0;
               col_nxt   = '0;
               di_nxt    = 2'd0;
               dj_nxt    = 2'd0;
            end
         end
         S_FETCH: state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_WRITE;
         S_WRITE: begin
            // Counters move only on cycles where the write actually commits
            if (ram_gnt) begin
               if (dj != f_m1) begin
                  dj_nxt = dj + 2'd1;
               end else begin
                  dj_nxt = 2'd0;
                  if (di != f_m1) begin
                     di_nxt = di + 2'd1;
                  end else begin
                     di_nxt = 2'd0;
                     if (last_pix) begin
                        state_nxt = S_DONE;
                     end else begin
                        state_nxt = S_FETCH;
                        if (col_end) begin
                           col_nxt = '0;
                           row_nxt = row + stride;
                        end else begin
                           col_nxt = col + stride;
                        end
                     end
                  end
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters, mode latch, ROM address and pixel register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         mode_q   <= M_X1;
         row      <= '0;
         col      <= '0;
         di       <= 2'd0;
         dj       <= 2'd0;
         pix      <= 8'd0;
         rom_addr <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         row   <= row_nxt;
         col   <= col_nxt;
         di    <= di_nxt;
         dj    <= dj_nxt;
         if (state == S_IDLE && start) begin
            mode_q <= mode_t'(mode);
         end
         // Load the address as FETCH is entered so the synchronous ROM
         // returns the pixel during LATCH
         if (state_nxt == S_FETCH) begin
            rom_addr <= row_nxt * SRC_W_R + col_nxt;
         end
         if (state == S_LATCH) begin
            pix <= rom_data;
         end
      end
   end

   // Destination address for the current write
   logic [WA_W-1:0] row_w, col_w, waddr;
   always_comb begin
      row_w = WA_W'(row);
      col_w = WA_W'(col);
      if (mode_q == M_DIV2) begin
         waddr = (row_w >> 1) * dw_w + (col_w >> 1);
      end else begin
         waddr = (row_w * f_w + WA_W'(di)) * dw_w + col_w * f_w + WA_W'(dj);
      end
   end

   // Status and RAM port outputs; write enable is confined to WRITE
   always_comb begin
      busy      = (state == S_FETCH) || (state == S_LATCH) || (state == S_WRITE);
      done      = (state == S_DONE);
      ram_we    = (state == S_WRITE) && ram_gnt;
      ram_waddr = (state == S_WRITE) ? waddr : '0;
      ram_wdata = pix;
   end

`ifdef RESIZE_CTRL_PERF_EN
   // Saturating count of WRITE cycles lost to a missing grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (state == S_IDLE && start) begin
         stall_cnt <= 16'd0;
      end else if (state == S_WRITE && !ram_gnt && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
